// File: rtl/softcore_cpu_cpu_ocimem_ctrl_pkg.sv
// softcore_CPU_cpu_debug_pkg
// Shared definitions for the on-chip debug memory controller:
//   - bit positions of the fields carried in the 38-bit JTAG data word (jdo)
//   - read-owner states used to route ram_rddata back to JTAG or the CPU
//   - JTAG OCI memory command encoding and its strobe precedence
package softcore_CPU_cpu_debug_pkg;

  localparam int JDO_W          = 38;
  localparam int JDO_ADDR_LSB   = 17;
  localparam int JDO_RD_ON_LOAD = 34;
  localparam int JDO_WDATA_MSB  = 34;
  localparam int JDO_WDATA_LSB  = 3;

  // Who owns the RAM read data returning in the current cycle.
  typedef enum logic [1:0] {
    R_NONE,
    R_JTAG,
    R_CPU
  } read_owner_e;

  // At most one JTAG command is acted on per cycle.
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_LOAD_ADDR,
    CMD_WRITE,
    CMD_READ
  } jtag_cmd_e;

  // Several strobes in one cycle collapse to a single command:
  // load-address beats write, which beats read.
  function automatic jtag_cmd_e decode_cmd(input logic take_a,
                                           input logic take_b,
                                           input logic no_action_a);
    if (take_a)      return CMD_LOAD_ADDR;
    if (take_b)      return CMD_WRITE;
    if (no_action_a) return CMD_READ;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/softcore_cpu_cpu_ocimem_ctrl_arb.sv
// softcore_CPU_cpu_ocimem_arb
// Issue multiplexer for the shared single-port debug RAM plus the read-owner
// FSM that remembers who issued last cycle's read.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   load_i/write_i/read_i   decoded (mutually exclusive) JTAG command
//   rd_on_load_i            load-address command also reads the new address
//   load_addr_i             address carried by the load-address command
//   mon_addr_i              current MonAReg value
//   jtag_wdata_i            JTAG write data
//   cpu_*                   Avalon debug-memory slave request / response
//   ram_*_o, ram_rddata_i   RAM port (address/controls combinational)
//   jtag_return_o           ram_rddata belongs to a JTAG read this cycle
module softcore_CPU_cpu_ocimem_arb
  import softcore_CPU_cpu_debug_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int ROM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              write_i,
  input  logic              read_i,
  input  logic              rd_on_load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [ADDR_W-1:0] mon_addr_i,
  input  logic [31:0]       jtag_wdata_i,
  input  logic [ADDR_W-1:0] cpu_address_i,
  input  logic              cpu_read_i,
  input  logic              cpu_write_i,
  input  logic [31:0]       cpu_writedata_i,
  input  logic [3:0]        cpu_byteenable_i,
  output logic [31:0]       cpu_readdata_o,
  output logic              cpu_waitrequest_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_be_o,
  output logic [31:0]       ram_wrdata_o,
  input  logic [31:0]       ram_rddata_i,
  output logic              jtag_return_o
);

  read_owner_e state_q, state_d;
  logic        jtag_any;
  logic        cpu_req;
  logic        cpu_go;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= R_NONE;
    else          state_q <= state_d;
  end

  always_comb begin
    jtag_any     = load_i | write_i | read_i;
    cpu_req      = cpu_read_i | cpu_write_i;
    // While in R_CPU the master is still presenting the request whose data
    // is returning now, so it must not be accepted a second time.
    cpu_go       = cpu_req & ~jtag_any & (state_q != R_CPU);

    ram_addr_o   = mon_addr_i;
    ram_we_o     = 1'b0;
    ram_be_o     = 4'hF;
    ram_wrdata_o = cpu_writedata_i;
    state_d      = R_NONE;

    if (load_i) begin
      ram_addr_o = load_addr_i;
      if (rd_on_load_i) state_d = R_JTAG;
    end else if (write_i) begin
      ram_we_o     = 1'b1;
      ram_wrdata_o = jtag_wdata_i;
    end else if (read_i) begin
      state_d = R_JTAG;
    end else if (cpu_go) begin
      ram_addr_o = cpu_address_i;
      if (cpu_write_i) begin
        ram_be_o = cpu_byteenable_i;
        // Writes into the protected low region complete but never land.
        ram_we_o = (int'(cpu_address_i) >= ROM_WORDS);
      end else begin
        state_d = R_CPU;
      end
    end

    if (!reset_n)               cpu_waitrequest_o = 1'b1;
    else if (state_q == R_CPU)  cpu_waitrequest_o = 1'b0;
    else if (cpu_req)           cpu_waitrequest_o = ~(cpu_go & cpu_write_i);
    else                        cpu_waitrequest_o = 1'b0;

    cpu_readdata_o = (state_q == R_CPU) ? ram_rddata_i : 32'h0;
    jtag_return_o  = (state_q == R_JTAG);
  end

endmodule

// File: rtl/softcore_cpu_cpu_ocimem_ctrl.sv
// softcore_cpu_cpu_ocimem_ctrl
// On-chip debug memory controller. Sequences the JTAG OCI memory strobes and
// shares one single-port debug RAM with the CPU's Avalon debug slave. Holds
// MonAReg, MonDReg and monitor_ready, which are scanned back to the host.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   jdo, take_action_ocimem_a/b,
//   take_no_action_ocimem_a           JTAG data word and command strobes
//   cpu_*                             Avalon debug-memory slave
//   ram_addr/we/be/wrdata, ram_rddata RAM port (1-cycle read latency)
//   MonAReg, MonDReg, monitor_ready   JTAG monitor registers
module softcore_cpu_cpu_ocimem_ctrl
  import softcore_CPU_cpu_debug_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int ROM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wrdata,
  input  logic [31:0]       ram_rddata,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready
);

  jtag_cmd_e         cmd;
  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_wdata;
  logic              jdo_rd_on_load;
  logic              jtag_return;
  logic              jdo_unused;

  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              ready_q, ready_d;

  assign cmd            = decode_cmd(take_action_ocimem_a, take_action_ocimem_b,
                                     take_no_action_ocimem_a);
  assign jdo_addr       = jdo[JDO_ADDR_LSB+ADDR_W-1:JDO_ADDR_LSB];
  assign jdo_wdata      = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
  assign jdo_rd_on_load = jdo[JDO_RD_ON_LOAD];
  assign jdo_unused     = ^{jdo[JDO_W-1:JDO_WDATA_MSB+1], jdo[JDO_WDATA_LSB-1:0]};

  softcore_CPU_cpu_ocimem_arb #(
    .ADDR_W   (ADDR_W),
    .ROM_WORDS(ROM_WORDS)
  ) u_arb (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_i           (cmd == CMD_LOAD_ADDR),
    .write_i          (cmd == CMD_WRITE),
    .read_i           (cmd == CMD_READ),
    .rd_on_load_i     (jdo_rd_on_load),
    .load_addr_i      (jdo_addr),
    .mon_addr_i       (mon_a_q),
    .jtag_wdata_i     (jdo_wdata),
    .cpu_address_i    (cpu_address),
    .cpu_read_i       (cpu_read),
    .cpu_write_i      (cpu_write),
    .cpu_writedata_i  (cpu_writedata),
    .cpu_byteenable_i (cpu_byteenable),
    .cpu_readdata_o   (cpu_readdata),
    .cpu_waitrequest_o(cpu_waitrequest),
    .ram_addr_o       (ram_addr),
    .ram_we_o         (ram_we),
    .ram_be_o         (ram_be),
    .ram_wrdata_o     (ram_wrdata),
    .ram_rddata_i     (ram_rddata),
    .jtag_return_o    (jtag_return)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_q <= '0;
      mon_d_q <= '0;
      ready_q <= 1'b0;
    end else begin
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      ready_q <= ready_d;
    end
  end

  // Returning JTAG read data is applied first; a command issued in the same
  // cycle then takes precedence (a new read clears ready, a write overwrites
  // MonDReg with the value the host just sent).
  always_comb begin
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    ready_d = ready_q;
    if (jtag_return) begin
      mon_d_d = ram_rddata;
      ready_d = 1'b1;
    end
    case (cmd)
      CMD_LOAD_ADDR: begin
        mon_a_d = jdo_addr;
        ready_d = 1'b0;
      end
      CMD_WRITE: begin
        mon_d_d = jdo_wdata;
        mon_a_d = mon_a_q + ADDR_W'(1);
      end
      CMD_READ: begin
        ready_d = 1'b0;
        mon_a_d = mon_a_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign MonAReg       = mon_a_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;

endmodule

// File: doc/softcore_cpu_cpu_ocimem_ctrl.md
# softcore_CPU_cpu_ocimem_ctrl

On-chip debug memory controller for the Nios II debug core. It sequences the single-strobe JTAG OCI memory commands (take_action_ocimem_a/b, take_no_action_ocimem_a, plus jdo) and shares one synchronous single-port debug RAM between those commands and the CPU's Avalon debug-memory slave. It also maintains the MonAReg, MonDReg and monitor_ready registers that the debug-slave TCK logic scans back to the host.

## Interface
Parameters:
- ADDR_W, 8: RAM word-address width (2^ADDR_W 32-bit words).
- ROM_WORDS, 64: words [0, ROM_WORDS-1] are write-protected from the CPU side. JTAG may write them.

Ports:
- clk  in  1  system clock. The block has one clock; reset is asynchronous and active-low.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  JTAG data word, valid in the strobe cycle.
- take_action_ocimem_a  in  1  one-cycle strobe: load address.
- take_action_ocimem_b  in  1  one-cycle strobe: write data, then post-increment the address.
- take_no_action_ocimem_a  in  1  one-cycle strobe: read, then post-increment the address.
- cpu_address  in  ADDR_W  CPU word address.
- cpu_read, cpu_write  in  1  Avalon read and write requests.
- cpu_writedata  in  32  CPU write data.
- cpu_byteenable  in  4  CPU byte enables.
- cpu_readdata  out  32  CPU read data.
- cpu_waitrequest  out  1  Avalon stall.
- ram_addr  out  ADDR_W  RAM address (combinational).
- ram_we  out  1  RAM write enable.
- ram_be  out  4  RAM byte enables.
- ram_wrdata  out  32  RAM write data.
- ram_rddata  in  32  RAM read data, valid 1 cycle after address.
- MonAReg  out  ADDR_W  JTAG address register.
- MonDReg  out  32  JTAG data register.
- monitor_ready  out  1  JTAG read data available.

## Operation
- jdo field map:
  - ocimem_a: jdo[ADDR_W+16:17] is the address and jdo[34] is read-on-load.
  - ocimem_b: jdo[34:3] is the write data.
- Per-cycle issue priority: JTAG strobe > CPU request. Strobes are never stalled. A losing CPU request sees cpu_waitrequest=1 and is held by the master.
- ocimem_a:
  - MonAReg <= jdo address; monitor_ready <= 0.
  - If jdo[34]=1, issue a read at the new address (ram_addr = jdo address in that cycle). MonAReg does not increment.
- ocimem_b: ram_we=1, ram_be=4'hF, ram_addr=MonAReg, ram_wrdata=jdo[34:3]; MonDReg <= jdo[34:3]; MonAReg <= MonAReg+1.
- take_no_action_ocimem_a: read at MonAReg; monitor_ready <= 0; MonAReg <= MonAReg+1.
- MonAReg increments wrap modulo 2^ADDR_W (all-ones -> 0).
- Read-owner FSM records who owns ram_rddata in the next cycle. States:
  - R_NONE: no read in flight.
  - R_JTAG: a JTAG read was issued last cycle.
  - R_CPU: a CPU read was issued last cycle.
- FSM transitions: the next state is set by this cycle's issue (JTAG read -> R_JTAG, CPU read -> R_CPU, otherwise -> R_NONE), from any state. Reads are pipelined, so a new access may issue in the same cycle that the previous read's data returns.
- R_JTAG data return: MonDReg <= ram_rddata; monitor_ready <= 1.
- R_CPU data return: cpu_readdata = ram_rddata; cpu_waitrequest=0.
- CPU read handshake:
  - Accept cycle: cpu_waitrequest=1; FSM -> R_CPU.
  - Next cycle: data is returned and waitrequest drops. The master must not re-issue in that cycle; the block does not re-accept while in R_CPU for the same request.
- CPU write: completes in its accept cycle (cpu_waitrequest=0) with ram_be=cpu_byteenable. If cpu_address < ROM_WORDS, ram_we stays 0 but the write still completes (silently dropped).
- Simultaneous ocimem_b and CPU write: the JTAG write happens; the CPU write stalls one cycle.
- More than one JTAG strobe in the same cycle: precedence is ocimem_a > ocimem_b > no_action_ocimem_a; the others are ignored.

## Timing
- Reset values: MonAReg=0, MonDReg=0, monitor_ready=0, FSM=R_NONE, cpu_readdata=0, cpu_waitrequest=1 (forced high while reset_n=0, low in R_NONE with no request).
- ram_* outputs are combinational from the strobes, the CPU request and MonAReg.
- RAM read latency is 1 cycle.
- JTAG read: strobe at cycle N; MonDReg and monitor_ready update at the end of N+1 (visible in N+2).
- CPU read: 2 cycles; CPU write: 1 cycle; add 1 cycle for each lost arbitration.
- Reset mid-read: the in-flight read is abandoned; no MonDReg or cpu_readdata update.

## Structure
- Shared package softcore_CPU_cpu_debug_pkg: jdo field bit positions, read-owner enum (R_NONE/R_JTAG/R_CPU), JTAG command precedence constants.
- One natural sub-module: softcore_CPU_cpu_ocimem_arb (issue mux plus read-owner FSM). The top level holds MonAReg, MonDReg and monitor_ready.

## Test plan
- ocimem_a with address=0x10 and jdo[34]=1, RAM[0x10]=0xCAFEF00D -> MonDReg=0xCAFEF00D and monitor_ready=1 at N+2; MonAReg=0x10.
- ocimem_a at 0xFE, then three ocimem_b writes 0x1, 0x2, 0x3 -> RAM[0xFE]=1, RAM[0xFF]=2, RAM[0x00]=3; MonAReg=0x01 (wrap).
- CPU write 0xDEADBEEF to word 5 (ROM) -> RAM unchanged, waitrequest low the same cycle. The same write to word 0x80 -> RAM updated.
- CPU read of 0x80 in the same cycle as ocimem_b -> cpu_waitrequest high for 1 extra cycle; CPU gets the correct data 3 cycles after first request.
- CPU read returning in the same cycle a JTAG read issues -> cpu_readdata and MonDReg each get their own word.
- reset_n low during R_JTAG -> monitor_ready=0 and MonDReg=0 after reset; no spurious update.
